// File: rtl/seq_gen_pkg.sv
// Shared types and defaults for the serial pattern generator.
// Optional bit stuffing is enabled by defining SEQ_GEN_STUFF_EN.
package seq_gen_pkg;

  // One-hot state encoding, same style as the run detector on the far end.
  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    SHIFT = 3'b010,
    STUFF = 3'b100
  } st_t;

  localparam int WIDTH_DEF   = 8;
  localparam int RUN_MAX_DEF = 3;

endpackage

// File: rtl/seq_run_tracker.sv
// Tracks the run length of identical line bits (payload and stuff bits alike)
// and requests a stuff bit once the run reaches RUN_MAX.
// Only instantiated when SEQ_GEN_STUFF_EN is defined.
module seq_run_tracker
  import seq_gen_pkg::*;
#(
  parameter int RUN_MAX = RUN_MAX_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic emit_i,      // a line bit is being launched this edge
  input  logic bit_i,       // value of that line bit
  output logic stuff_req_o  // the bit now on the line completed a full run
);

  localparam int               RUN_W   = $clog2(RUN_MAX + 1);
  localparam logic [RUN_W-1:0] RUN_LIM = RUN_W'(RUN_MAX);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

  logic [RUN_W-1:0] run_q, run_d;
  logic             last_q, last_d;

  // Next run length: extend on a repeated bit, restart at 1 on a change, clear on idle.
  always_comb begin
    run_d  = {RUN_W{1'b0}};
    last_d = last_q;
    if (emit_i) begin
      last_d = bit_i;
      if ((run_q != {RUN_W{1'b0}}) && (bit_i == last_q)) begin
        if (run_q == RUN_LIM) begin
          run_d = RUN_LIM;
        end else begin
          run_d = run_q + RUN_ONE;
        end
      end else begin
        run_d = RUN_ONE;
      end
    end else begin
      run_d  = {RUN_W{1'b0}};
      last_d = last_q;
    end
  end

  // Run length and last line bit registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      run_q  <= {RUN_W{1'b0}};
      last_q <= 1'b0;
    end else begin
      run_q  <= run_d;
      last_q <= last_d;
    end
  end

  assign stuff_req_o = (run_q == RUN_LIM);

endmodule

// File: rtl/seq_generator.sv
// Serial bit-stream transmitter: accepts WIDTH-bit words over valid/ready and
// shifts them out one line bit per cycle with a bit strobe.
// Define SEQ_GEN_STUFF_EN to insert complement stuff bits that cap runs of
// identical line bits at RUN_MAX.
module seq_generator
  import seq_gen_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter bit MSB_FIRST = 1'b1,
  parameter int RUN_MAX   = RUN_MAX_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             bit_o,
  output logic             bit_valid_o,
  output logic             stuffed_o,
  output logic             done_o,
  output logic             busy_o
);

  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Elaboration-time parameter sanity region; intentionally holds no logic.
  if (!((WIDTH >= 2) && (RUN_MAX >= 1))) begin : g_bad_cfg
  end

  st_t              state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;     // payload bits not yet on the line
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d; // index of the payload bit on the line
  logic             bit_q, bit_d;
  logic             bit_valid_q, bit_valid_d;
  logic             stuffed_q, stuffed_d;
  logic             stuff_req;
  logic             last_payload;
  logic             accept;
  logic             do_load, do_next;

  // Line order selects which end of the word leaves first.
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    logic b;
    if (MSB_FIRST) begin
      b = w[WIDTH-1];
    end else begin
      b = w[0];
    end
    return b;
  endfunction

  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] w);
    logic [WIDTH-1:0] r;
    if (MSB_FIRST) begin
      r = {w[WIDTH-2:0], 1'b0};
    end else begin
      r = {1'b0, w[WIDTH-1:1]};
    end
    return r;
  endfunction

`ifdef SEQ_GEN_STUFF_EN
  seq_run_tracker #(
    .RUN_MAX (RUN_MAX)
  ) u_run (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .emit_i      (bit_valid_d),
    .bit_i       (bit_d),
    .stuff_req_o (stuff_req)
  );
  assign stuffed_o = stuffed_q;
`else
  assign stuff_req = 1'b0;
  assign stuffed_o = 1'b0;
`endif

  assign last_payload = (bit_cnt_q == CNT_LAST);
  // Last line cycle of the word: final payload bit with no stuff behind it, or the trailing stuff bit.
  assign done_o  = ((state_q == SHIFT) && last_payload && !stuff_req) ||
                   ((state_q == STUFF) && last_payload);
  assign ready_o = (state_q == IDLE) || done_o;
  assign accept  = valid_i && ready_o;
  assign busy_o  = (state_q != IDLE);
  assign bit_o       = bit_q;
  assign bit_valid_o = bit_valid_q;

  // Next-state logic: choose between loading a word, sending the next payload bit, stuffing, or idling.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    bit_d       = 1'b0;
    bit_valid_d = 1'b0;
    stuffed_d   = 1'b0;
    do_load     = 1'b0;
    do_next     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          do_load = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
`ifdef SEQ_GEN_STUFF_EN
        if (stuff_req) begin
          state_d     = STUFF;
          bit_d       = ~bit_q;
          bit_valid_d = 1'b1;
          stuffed_d   = 1'b1;
        end else
`endif
        if (last_payload) begin
          if (accept) begin
            do_load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          do_next = 1'b1;
        end
      end
`ifdef SEQ_GEN_STUFF_EN
      STUFF: begin
        if (last_payload) begin
          if (accept) begin
            do_load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          do_next = 1'b1;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase

    if (do_load) begin
      state_d     = SHIFT;
      shreg_d     = shift_out(data_i);
      bit_d       = first_bit(data_i);
      bit_valid_d = 1'b1;
      bit_cnt_d   = {CNT_W{1'b0}};
    end else if (do_next) begin
      state_d     = SHIFT;
      shreg_d     = shift_out(shreg_q);
      bit_d       = first_bit(shreg_q);
      bit_valid_d = 1'b1;
      if (bit_cnt_q == CNT_SAT) begin
        bit_cnt_d = CNT_SAT;
      end else begin
        bit_cnt_d = bit_cnt_q + CNT_ONE;
      end
    end else begin
      bit_cnt_d = bit_cnt_q;
    end
  end

  // State, datapath and registered line outputs; reset discards any word in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      shreg_q     <= {WIDTH{1'b0}};
      bit_cnt_q   <= {CNT_W{1'b0}};
      bit_q       <= 1'b0;
      bit_valid_q <= 1'b0;
      stuffed_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      bit_q       <= bit_d;
      bit_valid_q <= bit_valid_d;
      stuffed_q   <= stuffed_d;
    end
  end

endmodule

// File: tb/tb_seq_generator.sv
// Scoreboard bench for seq_generator. Stimulus expands each accepted word into
// its expected line cycles; a negedge monitor pops and compares them.
// Honours SEQ_GEN_STUFF_EN in its reference model.
module tb_seq_generator;

  localparam int W    = 8;
  localparam bit MSBF = 1'b1;
  localparam int RMAX = 3;

  logic         clk     = 1'b0;
  logic         rst_i   = 1'b1;
  logic         valid_i = 1'b0;
  logic [W-1:0] data_i  = '0;
  logic ready_o, bit_o, bit_valid_o, stuffed_o, done_o, busy_o;

  seq_generator #(.WIDTH(W), .MSB_FIRST(MSBF), .RUN_MAX(RMAX)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .data_i      (data_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .bit_o       (bit_o),
    .bit_valid_o (bit_valid_o),
    .stuffed_o   (stuffed_o),
    .done_o      (done_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic b;
    logic s;
    logic d;
  } line_t;

  line_t exp_q[$];
  int    n_pass = 0;
  int    n_total = 0;
  bit    mon_en = 1'b0;
  bit    cur_valid = 1'b0;   // model: the cycle just checked carried a line bit
  int    model_run = 0;
  logic  model_last = 1'b0;
  int    mon_sz;
  line_t mon_e;

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endfunction

  // Reference model: a word becomes WIDTH payload bits, with a complement
  // stuff bit after any bit that brings the line run to RUN_MAX.
  function automatic void push_word(input logic [W-1:0] d, input bit contig);
    line_t e;
    if (!contig) model_run = 0;
    for (int i = 0; i < W; i++) begin
      logic b;
      b = MSBF ? d[W-1-i] : d[i];
      e.b = b; e.s = 1'b0; e.d = 1'b0;
      exp_q.push_back(e);
`ifdef SEQ_GEN_STUFF_EN
      model_run  = (model_run > 0 && b == model_last) ? model_run + 1 : 1;
      model_last = b;
      if (model_run >= RMAX) begin
        e.b = ~b; e.s = 1'b1; e.d = 1'b0;
        exp_q.push_back(e);
        model_run  = 1;
        model_last = ~b;
      end
`endif
    end
    e = exp_q.pop_back();
    e.d = 1'b1;
    exp_q.push_back(e);
  endfunction

  // Drive one cycle of inputs just after the monitor's negedge.
  task automatic step(input bit v, input logic [W-1:0] d, output bit acc);
    valid_i = v;
    data_i  = d;
    acc = v && (exp_q.size() == 0);
    if (acc) push_word(d, cur_valid);
    @(negedge clk); #1;
  endtask

  task automatic send(input logic [W-1:0] d);
    bit acc;
    acc = 1'b0;
    for (int k = 0; k < 64 && !acc; k++) step(1'b1, d, acc);
    chk("send_accept", {31'd0, acc}, 32'd1);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int k = 0; k < n; k++) step(1'b0, W'($urandom), acc);
  endtask

  task automatic do_reset();
    rst_i   = 1'b1;
    valid_i = 1'b0;
    exp_q.delete();
    model_run = 0;
    @(negedge clk); #1;
    rst_i = 1'b0;
  endtask

  // Monitor: compare every cycle against the head of the expected line.
  always @(negedge clk) begin
    if (mon_en) begin
      mon_sz = exp_q.size();
      chk("ready_o", {31'd0, ready_o}, {31'd0, (mon_sz <= 1)});
      chk("busy_o", {31'd0, busy_o}, {31'd0, (mon_sz > 0)});
      chk("bit_valid_o", {31'd0, bit_valid_o}, {31'd0, (mon_sz > 0)});
      if (mon_sz > 0) begin
        mon_e = exp_q.pop_front();
        if (bit_valid_o) begin
          chk("bit_o", {31'd0, bit_o}, {31'd0, mon_e.b});
          chk("stuffed_o", {31'd0, stuffed_o}, {31'd0, mon_e.s});
          chk("done_o", {31'd0, done_o}, {31'd0, mon_e.d});
        end
        cur_valid = 1'b1;
      end else begin
        chk("idle_bit_o", {31'd0, bit_o}, 32'd0);
        chk("idle_stuffed_o", {31'd0, stuffed_o}, 32'd0);
        chk("idle_done_o", {31'd0, done_o}, 32'd0);
        cur_valid = 1'b0;
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_bit_valid_o", {31'd0, bit_valid_o}, 32'd0);
    chk("rst_bit_o", {31'd0, bit_o}, 32'd0);
    chk("rst_busy_o", {31'd0, busy_o}, 32'd0);
    chk("rst_ready_o", {31'd0, ready_o}, 32'd1);
    chk("rst_done_o", {31'd0, done_o}, 32'd0);
    chk("rst_stuffed_o", {31'd0, stuffed_o}, 32'd0);
    #1;
    rst_i  = 1'b0;
    mon_en = 1'b1;

    // Single word, then idle.
    send(8'hA5);
    idle(10);
    // Back-to-back words with valid held.
    send(8'hA5);
    send(8'h3C);
    idle(10);
    // Long runs, stuffed or not depending on the build.
    send(8'hFF);
    idle(12);
    send(8'h00);
    send(8'hFF);
    send(8'h0F);
    idle(14);
    // Reset after three bits, then a clean new word.
    send(8'h0F);
    idle(2);
    do_reset();
    idle(2);
    send(8'hF0);
    idle(12);

    // Randomised traffic with random gaps and data churn while idle.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) != 0) send(W'($urandom));
      else idle($urandom_range(1, 3));
    end

    for (int k = 0; k < 200 && exp_q.size() > 0; k++) idle(1);
    chk("drain", exp_q.size(), 32'd0);
    idle(2);
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
